// File: rtl/dm_responder.sv
// Data-memory responder: word-addressed storage behind a one-entry posted
// write buffer, one-cycle read latency, sticky error and saturating counters.
module dm_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  DM_enable,
  input  logic                  DM_read,
  input  logic                  DM_write,
  input  logic [ADDR_WIDTH-1:0] DM_address,
  input  logic [DATA_WIDTH-1:0] DM_in,
  output logic [DATA_WIDTH-1:0] DM_out,
  output logic                  dm_valid,
  output logic                  dm_error,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  logic                  rd_cmd;
  logic                  wr_cmd;
  logic                  ill_cmd;
  logic                  in_range;
  logic                  wr_accept;
  logic [IDX_W-1:0]      idx;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  wb_valid;
  logic [IDX_W-1:0]      wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;

  logic [0:0]            state;

  assign rd_cmd    = DM_enable &  DM_read & ~DM_write;
  assign wr_cmd    = DM_enable &  DM_write & ~DM_read;
  assign ill_cmd   = DM_enable &  DM_read &  DM_write;
  assign in_range  = {1'b0, DM_address} < DEPTH_L;
  assign wr_accept = wr_cmd & in_range;
  assign idx       = DM_address[IDX_W-1:0];

  // Any valid buffer entry is committed on every non-reset edge: either it is
  // displaced by a new write or it drains on a cycle without one.
  // NOTE: the storage array is deliberately not reset; only the buffered,
  // uncommitted write is lost when reset is sampled.
  always_ff @(posedge clk) begin
    if (rst && wb_valid) begin
      mem[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= wr_accept;
    end
  end

  // Buffer address/data are qualified by wb_valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      wb_addr <= idx;
      wb_data <= DM_in;
    end
  end

  // NOTE: sequential state always uses non-blocking assignments so every
  // block samples the pre-edge values of wb_valid/wb_addr/wb_data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      DM_out <= '0;
    end else if (rd_cmd) begin
      if (!in_range) begin
        DM_out <= '0;
      end else if (wb_valid && (wb_addr == idx)) begin
        DM_out <= wb_data;
      end else begin
        DM_out <= mem[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else if (rd_cmd) begin
      state <= RESP;
    end else begin
      state <= IDLE;
    end
  end

  assign dm_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      dm_error <= 1'b0;
    end else if (ill_cmd || ((rd_cmd || wr_cmd) && !in_range)) begin
      dm_error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_cmd && (rd_count != '1)) begin
        rd_count <= rd_count + 1'b1;
      end
      if (wr_accept && (wr_count != '1)) begin
        wr_count <= wr_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed scenarios plus random traffic, checked
// against a last-written-value memory model with an undo record for reset.
module tb_dm_responder;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 2048;
  localparam int CNT_WIDTH  = 16;
  localparam int CMAX       = (1 << CNT_WIDTH) - 1;

  logic                  clk;
  logic                  rst;
  logic                  DM_enable;
  logic                  DM_read;
  logic                  DM_write;
  logic [ADDR_WIDTH-1:0] DM_address;
  logic [DATA_WIDTH-1:0] DM_in;
  logic [DATA_WIDTH-1:0] DM_out;
  logic                  dm_valid;
  logic                  dm_error;
  logic [CNT_WIDTH-1:0]  rd_count;
  logic [CNT_WIDTH-1:0]  wr_count;

  dm_responder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .DM_enable  (DM_enable),
    .DM_read    (DM_read),
    .DM_write   (DM_write),
    .DM_address (DM_address),
    .DM_in      (DM_in),
    .DM_out     (DM_out),
    .dm_valid   (dm_valid),
    .dm_error   (dm_error),
    .rd_count   (rd_count),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: every accepted write is visible immediately; a reset
  // sampled right after a write undoes that one write.
  logic [DATA_WIDTH-1:0] mm [int];
  bit                    u_valid = 1'b0;
  int                    u_addr;
  bit                    u_had;
  logic [DATA_WIDTH-1:0] u_old;

  logic [DATA_WIDTH-1:0] exp_out   = '0;
  bit                    out_known = 1'b0;
  bit                    exp_valid = 1'b0;
  bit                    exp_err   = 1'b0;
  int                    exp_rc    = 0;
  int                    exp_wc    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input bit r_n, input bit en, input bit rd,
                      input bit wr, input logic [ADDR_WIDTH-1:0] a,
                      input logic [DATA_WIDTH-1:0] d);
    bit is_rd, is_wr, is_ill, inr;
    int ai;
    rst        = r_n;
    DM_enable  = en;
    DM_read    = rd;
    DM_write   = wr;
    DM_address = a;
    DM_in      = d;
    @(posedge clk);
    #1;
    is_rd  = en && rd && !wr;
    is_wr  = en && wr && !rd;
    is_ill = en && rd && wr;
    ai     = int'(a);
    inr    = ai < DEPTH;
    if (!r_n) begin
      if (u_valid) begin
        if (u_had) mm[u_addr] = u_old;
        else mm.delete(u_addr);
      end
      u_valid   = 1'b0;
      exp_out   = '0;
      out_known = 1'b1;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      exp_rc    = 0;
      exp_wc    = 0;
    end else begin
      u_valid   = 1'b0;
      exp_valid = is_rd;
      if (is_rd) begin
        if (exp_rc < CMAX) exp_rc++;
        if (!inr) begin
          exp_out   = '0;
          out_known = 1'b1;
          exp_err   = 1'b1;
        end else if (mm.exists(ai)) begin
          exp_out   = mm[ai];
          out_known = 1'b1;
        end else begin
          out_known = 1'b0;
        end
      end
      if (is_wr) begin
        if (inr) begin
          u_valid = 1'b1;
          u_addr  = ai;
          u_had   = mm.exists(ai);
          if (u_had) u_old = mm[ai];
          mm[ai] = d;
          if (exp_wc < CMAX) exp_wc++;
        end else begin
          exp_err = 1'b1;
        end
      end
      if (is_ill) exp_err = 1'b1;
    end
    check({tag, ".valid"}, 64'(dm_valid), 64'(exp_valid));
    check({tag, ".error"}, 64'(dm_error), 64'(exp_err));
    check({tag, ".rd_count"}, 64'(rd_count), 64'(exp_rc));
    check({tag, ".wr_count"}, 64'(wr_count), 64'(exp_wc));
    if (out_known) check({tag, ".out"}, 64'(DM_out), 64'(exp_out));
  endtask

  task automatic do_rd(input string tag, input logic [ADDR_WIDTH-1:0] a);
    step(tag, 1'b1, 1'b1, 1'b1, 1'b0, a, $urandom);
  endtask

  task automatic do_wr(input string tag, input logic [ADDR_WIDTH-1:0] a,
                       input logic [DATA_WIDTH-1:0] d);
    step(tag, 1'b1, 1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic do_idle(input string tag);
    // Read/write strobes toggle while enable is low: still no command.
    step(tag, 1'b1, 1'b0, 1'($urandom), 1'($urandom), 12'($urandom), $urandom);
  endtask

  task automatic do_reset(input string tag);
    step(tag, 1'b0, 1'b1, 1'b1, 1'b0, 12'h010, $urandom);
  endtask

  logic [ADDR_WIDTH-1:0] rand_addrs [11];

  initial begin
    rand_addrs = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005,
                   12'h006, 12'h7FF, 12'h800, 12'hFFF, 12'h010};

    do_reset("reset0");
    do_reset("reset1");

    // Known pre-test contents, committed by the trailing idle.
    do_wr("pre_w0", 12'h000, 32'h0000_0000);
    do_wr("pre_w30", 12'h030, 32'h0BAD_F00D);
    do_wr("pre_w40", 12'h040, 32'h1234_5678);
    do_idle("pre_idle");
    do_reset("reset2");

    do_rd("rd0", 12'h000);
    do_idle("rd0_after");

    do_wr("fwd_w", 12'h010, 32'hDEAD_BEEF);
    do_rd("fwd_r", 12'h010);

    do_wr("w20", 12'h020, 32'h1111_1111);
    do_wr("w21", 12'h021, 32'h2222_2222);
    do_idle("i20a");
    do_idle("i20b");
    do_rd("r20", 12'h020);
    do_rd("r21", 12'h021);
    do_idle("r21_after");

    step("ill30", 1'b1, 1'b1, 1'b1, 1'b1, 12'h030, 32'h5A5A_5A5A);
    do_idle("ill_after");
    do_rd("r30", 12'h030);

    do_wr("ww50a", 12'h050, 32'hAAAA_0001);
    do_wr("ww50b", 12'h050, 32'hBBBB_0002);
    do_rd("ww50r", 12'h050);

    do_wr("oor_w", 12'h900, 32'h7777_7777);
    do_rd("oor_r", 12'h900);
    do_wr("drain_w", 12'h060, 32'h6060_6060);
    do_wr("drain_oor", 12'hA00, 32'h0000_0BAD);
    do_rd("drain_r", 12'h060);

    do_rd("midrd", 12'h010);
    do_reset("midrd_rst");

    do_wr("disc_w", 12'h040, 32'hCAFE_F00D);
    do_reset("disc_rst");
    do_rd("disc_r", 12'h040);
    do_idle("disc_idle");

    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 59);
      if (r == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd", 1'b1, 1'(r > 8), 1'($urandom), 1'($urandom),
             rand_addrs[$urandom_range(0, 10)], $urandom);
      end
    end

    do_reset("sat_rst");
    do_wr("sat_w", 12'h070, 32'h7070_7070);
    for (int i = 0; i < CMAX; i++) begin
      do_rd("sat_rd", 12'($urandom_range(0, DEPTH - 1)));
    end
    do_rd("sat_extra", 12'h070);
    do_rd("sat_oor", 12'h800);
    do_idle("sat_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder on the far side of the core's DM port. It accepts single-word read and write commands from the core (`DM_enable`/`DM_read`/`DM_write`, 12-bit word address), and holds a word-addressed storage array. Writes go through a one-entry posted write buffer with read forwarding. It returns read data with fixed one-cycle latency, and it keeps sticky error status plus saturating access counters for debug.

## Interface
- `ADDR_WIDTH`, 12: word address width; matches `DM_address`.
- `DATA_WIDTH`, 32: word width.
- `DEPTH`, 4096: implemented words; must be ≤ 2^ADDR_WIDTH.
- `CNT_WIDTH`, 16: width of the access counters.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `DM_enable`  in  1: command qualifier.
- `DM_read`  in  1: read command; valid only with `DM_enable`.
- `DM_write`  in  1: write command; valid only with `DM_enable`.
- `DM_address`  in  ADDR_WIDTH: word address.
- `DM_in`  in  DATA_WIDTH: write data from the core.
- `DM_out`  out  DATA_WIDTH: registered read data to the core.
- `dm_valid`  out  1: one-cycle pulse; `DM_out` was updated by the previous command.
- `dm_error`  out  1: sticky error flag.
- `rd_count`  out  CNT_WIDTH: accepted reads, saturating.
- `wr_count`  out  CNT_WIDTH: accepted writes, saturating.

## Operation
- Command decode, evaluated per cycle:
  - RD = enable & read & !write.
  - WR = enable & write & !read.
  - ILL = enable & read & write.
  - Enable low: no command, regardless of read/write.
- Storage: `mem[0:DEPTH-1]` has one write port and is not reset.
- Write buffer state is `wb_valid`, `wb_addr`, `wb_data`.
- On WR (in range):
  - If `wb_valid`, commit `mem[wb_addr]<=wb_data`.
  - Load the buffer with the new address and data; `wb_valid<=1`.
- Any cycle without an accepted WR while `wb_valid`: commit the buffer to `mem` and set `wb_valid<=0` (drain).
- On RD (in range):
  - If `wb_valid && wb_addr==DM_address`, `DM_out<=wb_data`; otherwise `DM_out<=mem[DM_address]`.
  - Forwarding takes priority over a drain in the same edge.
- `DM_out` holds its value until the next RD or out-of-range RD. WR and ILL never change it.
- Out of range (`DM_address >= DEPTH`):
  - RD sets `DM_out<=0`, `dm_valid` pulses, and `dm_error` is set.
  - WR is dropped: no buffer load, but a pending drain still proceeds. `dm_error` is set.
- ILL: no buffer or array change except a pending drain. `DM_out` and `dm_valid` are unchanged, and `dm_error` is set.
- Counters:
  - `rd_count` increments on every RD, including out-of-range.
  - `wr_count` increments on in-range WR only.
  - Both hold at all-ones.
- Response FSM:
  - IDLE → RESP on any RD. RESP → RESP on a back-to-back RD; otherwise RESP → IDLE.
  - `dm_valid` = (state==RESP).

## Timing
- Reset (rst low at an edge) sets:
  - `DM_out=0`, `dm_valid=0`, `dm_error=0`, `rd_count=0`, `wr_count=0`, `wb_valid=0`, FSM=IDLE.
  - A buffered, uncommitted write is discarded; `mem` contents are otherwise kept.
- Reset asserted mid-read: the pending response is cancelled and `dm_valid` is 0 in the next cycle.
- Read latency is one cycle:
  - A RD sampled at edge N gives `DM_out` and `dm_valid=1` during cycle N+1.
  - Full throughput: one command per cycle.
- Write, then read of the same address on the next cycle returns the new data (forwarded).
- Reads of any older write return committed data.
- Two writes to the same address back-to-back: the second overwrites the buffer, and the first commits. A later read returns the second write's data.
- Write latency to `mem`:
  - Committed on the first edge with no WR.
  - Otherwise committed when displaced by the next WR.

## Test plan
- Reset, then RD at address 0x000: `DM_out=0`, `dm_valid` pulses one cycle later, `rd_count=1`, `dm_error=0`.
- WR 0x010←0xDEADBEEF, then RD 0x010 on the very next cycle: `DM_out=0xDEADBEEF` via forwarding, with `wr_count=1`.
- WR 0x020←0x11111111, WR 0x021←0x22222222, two idle cycles, then RD 0x020 and RD 0x021 back-to-back:
  - Returns 0x11111111, then 0x22222222.
  - `dm_valid` stays high for two cycles.
- ILL (read and write both high) at 0x030 with `DM_in=0x5A5A5A5A`: `dm_error=1` and stays set. A later RD 0x030 returns the prior contents. `DM_out` and `dm_valid` are unchanged during the ILL.
- WR 0x040←0xCAFEF00D, then `rst` low on the next edge before any idle cycle, then RD 0x040: returns the pre-test contents (write discarded), and all counters are 0 before the read.
- Drive 0xFFFF RDs, then one more: `rd_count` holds at 0xFFFF. With DEPTH=2048, RD 0x800 gives `DM_out=0` and `dm_error=1`.
